// File: rtl/sseg_pkg.sv
// rtl/sseg_pkg.sv - shared segment types and hex-to-segment constants
//
// Purpose: segment pattern type, blink phase encoding and hex digit glyphs
// shared by the seven-segment scan controller and its users.
// Ports:   none (package).

package sseg_pkg;

  // Segment pattern, bit order {dp,g,f,e,d,c,b,a}, 1 = lit.
  typedef logic [7:0] seg_t;

  // Blink phase; the on phase is the reset value.
  typedef enum logic {
    BLINK_ON  = 1'b0,
    BLINK_OFF = 1'b1
  } blink_phase_t;

  localparam seg_t SEG_HEX_0 = 8'h3F;
  localparam seg_t SEG_HEX_1 = 8'h06;
  localparam seg_t SEG_HEX_2 = 8'h5B;
  localparam seg_t SEG_HEX_3 = 8'h4F;
  localparam seg_t SEG_HEX_4 = 8'h66;
  localparam seg_t SEG_HEX_5 = 8'h6D;
  localparam seg_t SEG_HEX_6 = 8'h7D;
  localparam seg_t SEG_HEX_7 = 8'h07;
  localparam seg_t SEG_HEX_8 = 8'h7F;
  localparam seg_t SEG_HEX_9 = 8'h6F;
  localparam seg_t SEG_HEX_A = 8'h77;
  localparam seg_t SEG_HEX_B = 8'h7C;
  localparam seg_t SEG_HEX_C = 8'h39;
  localparam seg_t SEG_HEX_D = 8'h5E;
  localparam seg_t SEG_HEX_E = 8'h79;
  localparam seg_t SEG_HEX_F = 8'h71;

  function automatic seg_t hex_to_seg(input logic [3:0] nibble);
    seg_t pat;
    case (nibble)
      4'h0:    pat = SEG_HEX_0;
      4'h1:    pat = SEG_HEX_1;
      4'h2:    pat = SEG_HEX_2;
      4'h3:    pat = SEG_HEX_3;
      4'h4:    pat = SEG_HEX_4;
      4'h5:    pat = SEG_HEX_5;
      4'h6:    pat = SEG_HEX_6;
      4'h7:    pat = SEG_HEX_7;
      4'h8:    pat = SEG_HEX_8;
      4'h9:    pat = SEG_HEX_9;
      4'hA:    pat = SEG_HEX_A;
      4'hB:    pat = SEG_HEX_B;
      4'hC:    pat = SEG_HEX_C;
      4'hD:    pat = SEG_HEX_D;
      4'hE:    pat = SEG_HEX_E;
      default: pat = SEG_HEX_F;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/sync2.sv
// rtl/sync2.sv - two-flop synchroniser with asynchronous active-low reset
//
// Purpose: bring an asynchronous level into the clk domain.
// Ports:   clk   in  sampling clock
//          rst_n in  asynchronous active-low reset, clears both flops
//          d     in  asynchronous input level
//          q     out synchronised level, two clk edges behind d

module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/sseg_scan_ctrl.sv
// rtl/sseg_scan_ctrl.sv - multiplexed seven-segment scan controller
//
// Purpose: time-multiplexes NUM_DIGITS segment patterns onto one shared
// segment bus with per-slot anti-ghost blanking, day/night duty control and
// whole-display blinking.
// Ports:   clock_50_clk  in  system clock, rising edge
//          reset_reset_n in  asynchronous active-low reset
//          wr_en         in  one-cycle write strobe for the digit registers
//          wr_addr       in  digit index to write (out-of-range ignored)
//          wr_data       in  segment pattern {dp,g,f,e,d,c,b,a}
//          daylight      in  asynchronous day indicator, 1 = day
//          blink_en      in  1 = blink the whole display
//          sseg          out registered segment drive, 1 = lit
//          sel           out registered one-hot digit select
//          frame_tick    out registered pulse at the start of every frame

module sseg_scan_ctrl
  import sseg_pkg::*;
#(
  parameter int NUM_DIGITS = 16,
  parameter int SCAN_DIV   = 3125,
  parameter int BLANK      = 64,
  parameter int DUTY_DAY   = 3000,
  parameter int DUTY_NIGHT = 800,
  parameter int BLINK_DIV  = 32
) (
  input  logic                  clock_50_clk,
  input  logic                  reset_reset_n,
  input  logic                  wr_en,
  input  logic [3:0]            wr_addr,
  input  logic [7:0]            wr_data,
  input  logic                  daylight,
  input  logic                  blink_en,
  output logic [7:0]            sseg,
  output logic [NUM_DIGITS-1:0] sel,
  output logic                  frame_tick
);

  // Slot counter is wide enough to also hold SCAN_DIV itself, since the
  // duty limits may equal SCAN_DIV.
  localparam int SW = $clog2(SCAN_DIV + 1);
  localparam int DW = $clog2(NUM_DIGITS);
  localparam int FW = $clog2(BLINK_DIV + 1);

  localparam logic [SW-1:0]         SLOT_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [SW-1:0]         BLANK_END  = SW'(BLANK);
  localparam logic [SW-1:0]         DUTY_D     = SW'(DUTY_DAY);
  localparam logic [SW-1:0]         DUTY_N     = SW'(DUTY_NIGHT);
  localparam logic [DW-1:0]         DIG_LAST   = DW'(NUM_DIGITS - 1);
  localparam logic [FW-1:0]         FRAME_LAST = FW'(BLINK_DIV - 1);
  localparam logic [4:0]            NUM_DIG5   = 5'(NUM_DIGITS);
  localparam logic [NUM_DIGITS-1:0] SEL_ONE    = NUM_DIGITS'(1);

  seg_t         digit_mem [NUM_DIGITS];
  logic [SW-1:0] slot_cnt;
  logic [DW-1:0] dig_idx;
  logic [FW-1:0] frame_cnt;
  blink_phase_t  blink_phase;

  // Per-slot snapshot, valid from slot_cnt==1 onward.
  seg_t pat_q;
  logic day_q;
  logic dark_q;

  logic day_s;
  logic slot_start;
  logic wr_hit;

  logic [SW-1:0]         duty;
  logic                  lit;
  logic [NUM_DIGITS-1:0] sel_d;
  seg_t                  sseg_d;
  logic                  tick_d;

  sync2 u_day_sync (
    .clk   (clock_50_clk),
    .rst_n (reset_reset_n),
    .d     (daylight),
    .q     (day_s)
  );

  assign slot_start = (slot_cnt == '0);
  assign wr_hit     = wr_en && ({1'b0, wr_addr} < NUM_DIG5);

  always_ff @(posedge clock_50_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        digit_mem[i] <= '0;
      end
    end else if (wr_hit) begin
      digit_mem[wr_addr[DW-1:0]] <= wr_data;
    end
  end

  // Scan position and blink phase; the phase runs whether or not blinking
  // is enabled so enabling it always lands on the same frame grid.
  always_ff @(posedge clock_50_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      slot_cnt    <= '0;
      dig_idx     <= '0;
      frame_cnt   <= '0;
      blink_phase <= BLINK_ON;
    end else if (slot_cnt == SLOT_LAST) begin
      slot_cnt <= '0;
      if (dig_idx == DIG_LAST) begin
        dig_idx <= '0;
        if (frame_cnt == FRAME_LAST) begin
          frame_cnt   <= '0;
          blink_phase <= (blink_phase == BLINK_ON) ? BLINK_OFF : BLINK_ON;
        end else begin
          frame_cnt <= frame_cnt + FW'(1);
        end
      end else begin
        dig_idx <= dig_idx + DW'(1);
      end
    end else begin
      slot_cnt <= slot_cnt + SW'(1);
    end
  end

  // Snapshot taken once per slot so register writes, day/night changes and
  // blink_en changes never alter a slot that is already being shown.
  always_ff @(posedge clock_50_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      pat_q  <= '0;
      day_q  <= 1'b0;
      dark_q <= 1'b0;
    end else if (slot_start) begin
      pat_q  <= digit_mem[dig_idx];
      day_q  <= day_s;
      dark_q <= blink_en && (blink_phase == BLINK_OFF);
    end
  end

  // BLANK >= 1, so the lit window never includes slot_cnt==0 where the
  // snapshot is still being taken.
  always_comb begin
    duty   = DUTY_N;
    lit    = 1'b0;
    sel_d  = '0;
    sseg_d = '0;
    tick_d = slot_start && (dig_idx == '0);
    if (day_q) begin
      duty = DUTY_D;
    end
    lit = !dark_q && (slot_cnt >= BLANK_END) && (slot_cnt < duty);
    if (lit) begin
      sel_d  = SEL_ONE << dig_idx;
      sseg_d = pat_q;
    end
  end

  always_ff @(posedge clock_50_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      sseg       <= '0;
      sel        <= '0;
      frame_tick <= 1'b0;
    end else begin
      sseg       <= sseg_d;
      sel        <= sel_d;
      frame_tick <= tick_d;
    end
  end

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// tb/tb_sseg_scan_ctrl.sv - directed table-driven bench for sseg_scan_ctrl

module tb_sseg_scan_ctrl;
  import sseg_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       daylight;
  logic       blink_en;
  logic [7:0] sseg;
  logic [3:0] sel;
  logic       frame_tick;

  int n_total = 0;
  int n_pass  = 0;
  int off     = 0;

  typedef struct {
    int         off;
    logic [3:0] sel;
    logic [7:0] seg;
    logic       tick;
  } vec_t;

  vec_t vecs[18];
  logic lit_exp[7];

  sseg_scan_ctrl #(
    .NUM_DIGITS (4),
    .SCAN_DIV   (16),
    .BLANK      (2),
    .DUTY_DAY   (14),
    .DUTY_NIGHT (4),
    .BLINK_DIV  (2)
  ) dut (
    .clock_50_clk  (clk),
    .reset_reset_n (rst_n),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .daylight      (daylight),
    .blink_en      (blink_en),
    .sseg          (sseg),
    .sel           (sel),
    .frame_tick    (frame_tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  task automatic step();
    @(negedge clk);
    n_total++;
    if ($onehot0(sel) && (sel != 4'b0000 || sseg == 8'h00)) n_pass++;
    else $display("FAIL invariant at %0t: sel %b sseg %h", $time, sel, sseg);
  endtask

  task automatic goto(input int k);
    while (off < k) begin
      step();
      off++;
    end
  endtask

  task automatic wait_tick();
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!frame_tick && n < 200);
    check("frame_tick_wait", {31'd0, frame_tick}, 32'd1);
    off = 0;
  endtask

  task automatic chk_out(input string name, input logic [3:0] s, input logic [7:0] g);
    check(name, {20'd0, sel, sseg}, {20'd0, s, g});
  endtask

  initial begin
    vecs[0]  = '{0,  4'b0000, 8'h00, 1'b1};
    vecs[1]  = '{1,  4'b0000, 8'h00, 1'b0};
    vecs[2]  = '{2,  4'b0001, 8'h3F, 1'b0};
    vecs[3]  = '{13, 4'b0001, 8'h3F, 1'b0};
    vecs[4]  = '{14, 4'b0000, 8'h00, 1'b0};
    vecs[5]  = '{16, 4'b0000, 8'h00, 1'b0};
    vecs[6]  = '{17, 4'b0000, 8'h00, 1'b0};
    vecs[7]  = '{18, 4'b0010, 8'h06, 1'b0};
    vecs[8]  = '{29, 4'b0010, 8'h06, 1'b0};
    vecs[9]  = '{30, 4'b0000, 8'h00, 1'b0};
    vecs[10] = '{34, 4'b0100, 8'h5B, 1'b0};
    vecs[11] = '{45, 4'b0100, 8'h5B, 1'b0};
    vecs[12] = '{47, 4'b0000, 8'h00, 1'b0};
    vecs[13] = '{50, 4'b1000, 8'h4F, 1'b0};
    vecs[14] = '{61, 4'b1000, 8'h4F, 1'b0};
    vecs[15] = '{62, 4'b0000, 8'h00, 1'b0};
    vecs[16] = '{63, 4'b0000, 8'h00, 1'b0};
    vecs[17] = '{64, 4'b0000, 8'h00, 1'b1};
    lit_exp  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

    rst_n = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    daylight = 1'b1; blink_en = 1'b0;
    #1 rst_n = 1'b0;
    repeat (3) step();
    check("reset_sel", {28'd0, sel}, 32'd0);
    check("reset_sseg", {24'd0, sseg}, 32'd0);
    check("reset_tick", {31'd0, frame_tick}, 32'd0);

    rst_n = 1'b1;
    step();
    check("first_tick", {31'd0, frame_tick}, 32'd1);
    off = 0;
    for (int d = 0; d < 4; d++) begin
      wr_en = 1'b1; wr_addr = 4'(d); wr_data = hex_to_seg(4'(d));
      goto(off + 1);
    end
    wr_en = 1'b0;

    // full daylight frame from the table
    wait_tick();
    for (int i = 0; i < 18; i++) begin
      goto(vecs[i].off);
      check($sformatf("day_vec_off%0d", vecs[i].off),
            {19'd0, sel, sseg, frame_tick},
            {19'd0, vecs[i].sel, vecs[i].seg, vecs[i].tick});
    end
    off = 0;

    // night: mid-slot change waits for the next slot boundary
    daylight = 1'b0;
    goto(13); chk_out("night_d0_still_day", 4'b0001, 8'h3F);
    goto(14); chk_out("night_d0_blank", 4'b0000, 8'h00);
    goto(17); chk_out("night_d1_preblank", 4'b0000, 8'h00);
    goto(18); chk_out("night_d1_on0", 4'b0010, 8'h06);
    goto(19); chk_out("night_d1_on1", 4'b0010, 8'h06);
    goto(20); chk_out("night_d1_off", 4'b0000, 8'h00);
    daylight = 1'b1;
    goto(29); chk_out("night_d1_hold", 4'b0000, 8'h00);
    goto(34); chk_out("day_back_d2", 4'b0100, 8'h5B);
    goto(45); chk_out("day_back_d2_end", 4'b0100, 8'h5B);

    // write to the lit digit and to an out-of-range address
    wait_tick();
    goto(5);
    wr_en = 1'b1; wr_addr = 4'd0; wr_data = 8'hFF;
    goto(6);
    wr_addr = 4'd5; wr_data = 8'hAA;
    goto(7);
    wr_en = 1'b0;
    chk_out("wr_mid_slot_old", 4'b0001, 8'h3F);
    goto(13); chk_out("wr_slot_end_old", 4'b0001, 8'h3F);
    goto(18); chk_out("wr_addr5_ignored_d1", 4'b0010, 8'h06);
    goto(34); chk_out("wr_addr5_ignored_d2", 4'b0100, 8'h5B);
    goto(50); chk_out("wr_addr5_ignored_d3", 4'b1000, 8'h4F);
    wait_tick();
    goto(2); chk_out("wr_new_value", 4'b0001, 8'hFF);

    // asynchronous reset at slot_cnt 7 of digit 2
    goto(39); chk_out("pre_reset_d2", 4'b0100, 8'h5B);
    #2 rst_n = 1'b0;
    #1 check("async_reset_outs", {19'd0, sel, sseg, frame_tick}, 32'd0);
    step();
    step();
    rst_n = 1'b1;
    step();
    check("post_reset_tick", {31'd0, frame_tick}, 32'd1);
    off = 0;
    goto(1);  chk_out("post_reset_blank", 4'b0000, 8'h00);
    goto(2);  chk_out("post_reset_d0", 4'b0001, 8'h00);
    goto(18); chk_out("post_reset_d1", 4'b0010, 8'h00);
    goto(34); chk_out("post_reset_d2", 4'b0100, 8'h00);
    goto(50); chk_out("post_reset_d3", 4'b1000, 8'h00);

    // blink: frame numbering restarts at the reset release above
    blink_en = 1'b1;
    for (int f = 1; f <= 6; f++) begin
      wait_tick();
      goto(2);
      chk_out($sformatf("blink_f%0d_d0", f), lit_exp[f] ? 4'b0001 : 4'b0000, 8'h00);
      if (f < 6) begin
        goto(50);
        chk_out($sformatf("blink_f%0d_d3", f), lit_exp[f] ? 4'b1000 : 4'b0000, 8'h00);
      end else begin
        goto(20);
        blink_en = 1'b0;
        goto(25); chk_out("blink_off_mid_slot", 4'b0000, 8'h00);
        goto(34); chk_out("blink_off_next_slot", 4'b0100, 8'h00);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
